// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// The master side is the sequencer: it reads the status inputs and drives
// every select, enable and strobe.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
);
  // Status from the datapath / memory
  logic [OP_W-1:0]  opcode;
  logic             zero;
  logic             mem_ready;

  // Controls to the datapath / memory
  logic             pc_en;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;

  // Status / debug
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           illegal, state, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
           illegal, state, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer.
// One FSM walks fetch/decode/execute/memory/writeback over the shared memory
// and ALU. Controls are Moore functions of the state, except that the PC and
// IR load enables in FETCH wait for mem_ready and the BRANCH PC load follows
// the ALU zero flag. All write strobes are masked while reset is asserted so
// nothing in the datapath is modified in the cycle reset is sampled.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  mips_multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTEXEC   = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'('h2B);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'('h08);
  localparam logic [OP_W-1:0] OP_J     = OP_W'('h02);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_illegal;
  logic             w_illegal_next;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_retire;

  logic             w_pc_en;
  logic             w_iord;
  logic             w_mem_read;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_reg_dst;
  logic             w_mem_to_reg;
  logic             w_reg_write;
  logic             w_alu_src_a;
  logic [1:0]       w_alu_src_b;
  logic [1:0]       w_alu_op;
  logic [1:0]       w_pc_src;

  // State, illegal-opcode flag and retired-instruction counter registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_FETCH;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state   <= w_state_next;
      r_illegal <= w_illegal_next;
      if (w_retire) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  // Next-state decode and per-state datapath controls
  always_comb begin
    w_state_next   = S_FETCH;
    w_illegal_next = 1'b0;
    w_retire       = 1'b0;
    w_pc_en        = 1'b0;
    w_iord         = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_ir_write     = 1'b0;
    w_reg_dst      = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_reg_write    = 1'b0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = 2'b00;
    w_alu_op       = 2'b00;
    w_pc_src       = 2'b00;

    case (r_state)
      S_FETCH: begin
        // PC+4 is computed by the ALU while the instruction is read
        w_iord      = 1'b0;
        w_mem_read  = 1'b1;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b00;
        w_pc_src    = 2'b00;
        w_ir_write  = bus.mem_ready;
        w_pc_en     = bus.mem_ready;
        w_state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        w_alu_src_a = 1'b0;
        w_alu_src_b = 2'b11;
        w_alu_op    = 2'b00;
        case (bus.opcode)
          OP_RTYPE:     w_state_next = S_RTEXEC;
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_ADDI:      w_state_next = S_ADDIEXEC;
          OP_J:         w_state_next = S_JUMP;
          default: begin
            w_state_next   = S_FETCH;
            w_illegal_next = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_alu_op     = 2'b00;
        w_state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord       = 1'b1;
        w_mem_read   = 1'b1;
        w_state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWR: begin
        // Store strobe is held until memory acknowledges
        w_iord       = 1'b1;
        w_mem_write  = 1'b1;
        w_retire     = bus.mem_ready;
        w_state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b10;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_dst    = 1'b1;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        // Compare rs-rt; PC takes ALUOut only when they were equal
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b01;
        w_pc_src     = 2'b01;
        w_pc_en      = bus.zero;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_ADDIEXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_alu_op     = 2'b00;
        w_state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src     = 2'b10;
        w_pc_en      = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      default: begin
        // Unused encodings recover to FETCH with every control low
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Write strobes are masked during reset; selects pass straight through
  assign bus.pc_en       = w_pc_en     & ~i_reset;
  assign bus.ir_write    = w_ir_write  & ~i_reset;
  assign bus.reg_write   = w_reg_write & ~i_reset;
  assign bus.mem_write   = w_mem_write & ~i_reset;
  assign bus.iord        = w_iord;
  assign bus.mem_read    = w_mem_read;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.alu_op      = w_alu_op;
  assign bus.pc_src      = w_pc_src;
  assign bus.illegal     = r_illegal;
  assign bus.state       = r_state;
  assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// Each instruction is expanded into the list of states it must visit (from its
// opcode and the wait cycles chosen for it); every cycle the state, the full
// control word, the illegal flag and the retired count are compared with the
// values the reference derives from that list.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 32;
  localparam int OP_W  = 6;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                 ST_MEMWB = 4, ST_MEMWR = 5, ST_RTEXEC = 6, ST_ALUWB = 7,
                 ST_BRANCH = 8, ST_ADDIEXEC = 9, ST_ADDIWB = 10, ST_JUMP = 11;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  logic clk;
  logic reset;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W), .OP_W(OP_W)) bus ();

  mips_multicycle_ctrl #(.CNT_W(CNT_W), .OP_W(OP_W)) dut (
    .i_clock (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int n_cmp;
  int n_bad;
  logic [CNT_W-1:0] cnt_model;
  bit pend_illegal;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: every wait in this bench is a fixed number of clock edges
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Control word each state must present (before reset masking)
  function automatic ctrl_t expect_ctrl(input int st, input bit rdy, input bit z);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_en = rdy; end
      ST_DECODE:   begin c.alu_src_b = 2'b11; end
      ST_MEMADR:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_MEMRD:    begin c.iord = 1; c.mem_read = 1; end
      ST_MEMWB:    begin c.mem_to_reg = 1; c.reg_write = 1; end
      ST_MEMWR:    begin c.iord = 1; c.mem_write = 1; end
      ST_RTEXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      ST_ALUWB:    begin c.reg_dst = 1; c.reg_write = 1; end
      ST_BRANCH:   begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
      ST_ADDIEXEC: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      ST_ADDIWB:   begin c.reg_write = 1; end
      ST_JUMP:     begin c.pc_src = 2'b10; c.pc_en = 1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  // One clock cycle: drive inputs, compare everything, advance past the edge.
  // Entered and left just after a rising edge.
  task automatic step(input int st, input bit rdy, input bit z, input bit ill);
    ctrl_t e;
    ctrl_t got;
    bus.mem_ready = rdy;
    bus.zero      = z;
    #1;
    e = expect_ctrl(st, rdy, z);
    if (reset) begin
      e.pc_en = 0; e.ir_write = 0; e.reg_write = 0; e.mem_write = 0;
    end
    got = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
           bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
           bus.alu_src_b, bus.alu_op, bus.pc_src};
    check("state", 64'(bus.state), 64'(st));
    check("ctrl", 64'(got), 64'(e));
    check("illegal", 64'(bus.illegal), 64'(ill));
    check("instr_count", 64'(bus.instr_count), 64'(cnt_model));
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [OP_W-1:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
           (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
  endfunction

  // Runs one instruction through the expected state path.
  // fw / mw are the wait cycles inserted in FETCH and in the memory state.
  task automatic run_instr(input logic [OP_W-1:0] op, input int fw, input int mw, input bit z);
    bit ill;
    bit legal;
    int ncyc;
    ill = pend_illegal;
    legal = is_legal(op);
    bus.opcode = op;
    ncyc = 0;
    for (int i = 0; i <= fw; i++) begin
      step(ST_FETCH, (i == fw), z, ill);
      ill = 0;
      ncyc++;
    end
    step(ST_DECODE, 1'($urandom_range(0, 1)), z, 0);
    ncyc++;
    case (op)
      6'h00: begin
        step(ST_RTEXEC, 1'($urandom_range(0, 1)), z, 0);
        step(ST_ALUWB,  1'($urandom_range(0, 1)), z, 0);
        ncyc += 2;
      end
      6'h23: begin
        step(ST_MEMADR, 1'($urandom_range(0, 1)), z, 0);
        for (int i = 0; i <= mw; i++) step(ST_MEMRD, (i == mw), z, 0);
        step(ST_MEMWB, 1'($urandom_range(0, 1)), z, 0);
        ncyc += mw + 3;
      end
      6'h2B: begin
        step(ST_MEMADR, 1'($urandom_range(0, 1)), z, 0);
        for (int i = 0; i <= mw; i++) step(ST_MEMWR, (i == mw), z, 0);
        ncyc += mw + 2;
      end
      6'h04: begin
        step(ST_BRANCH, 1'($urandom_range(0, 1)), z, 0);
        ncyc += 1;
      end
      6'h08: begin
        step(ST_ADDIEXEC, 1'($urandom_range(0, 1)), z, 0);
        step(ST_ADDIWB,   1'($urandom_range(0, 1)), z, 0);
        ncyc += 2;
      end
      6'h02: begin
        step(ST_JUMP, 1'($urandom_range(0, 1)), z, 0);
        ncyc += 1;
      end
      default: ;
    endcase
    if (legal) cnt_model = cnt_model + 1'b1;
    pend_illegal = !legal;
    $display("instr op=0x%02h fetch_waits=%0d mem_waits=%0d zero=%0d cycles=%0d legal=%0d count=%0d",
             op, fw, mw, z, ncyc, legal, cnt_model);
  endtask

  initial begin
    logic [OP_W-1:0] op;
    int sel;
    n_cmp = 0;
    n_bad = 0;
    cnt_model = '0;
    pend_illegal = 0;
    reset = 1'b1;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset held for three sampling edges; strobes masked while it is high
    repeat (2) @(posedge clk);
    #1;
    step(ST_FETCH, 1'b1, 1'b1, 0);
    reset = 1'b0;

    // Directed cases
    run_instr(6'h00, 0, 0, 0);   // R-type: 0,1,6,7
    run_instr(6'h23, 0, 2, 0);   // lw with two MEMRD waits
    run_instr(6'h04, 0, 0, 1);   // beq taken
    run_instr(6'h04, 0, 0, 0);   // beq not taken
    run_instr(6'h3F, 0, 0, 0);   // illegal opcode
    run_instr(6'h08, 1, 0, 0);   // addi with a fetch wait
    run_instr(6'h2B, 0, 3, 1);   // sw with three MEMWR waits

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (is_legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Counter wrap: preload all-ones, then a jump retires and wraps to zero
    force dut.r_instr_count = '1;
    #1;
    release dut.r_instr_count;
    cnt_model = '1;
    run_instr(6'h02, 0, 0, 0);
    check("count_wrapped", 64'(bus.instr_count), 64'(0));
    run_instr(6'h00, 0, 0, 0);

    // Reset while a store is stalled in MEMWR
    bus.opcode = 6'h2B;
    step(ST_FETCH, 1'b1, 1'b0, pend_illegal);
    pend_illegal = 0;
    step(ST_DECODE, 1'b1, 1'b0, 0);
    step(ST_MEMADR, 1'b1, 1'b0, 0);
    step(ST_MEMWR, 1'b0, 1'b0, 0);
    reset = 1'b1;
    step(ST_MEMWR, 1'b0, 1'b0, 0);
    cnt_model = '0;
    step(ST_FETCH, 1'b0, 1'b0, 0);
    reset = 1'b0;
    $display("reset during stalled sw: state=%0d mem_write=%0d count=%0d",
             bus.state, bus.mem_write, bus.instr_count);
    run_instr(6'h04, 0, 0, 1);
    run_instr(6'h23, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control sequencer for the MIPS core in its multicycle form. One FSM sequences fetch, decode, execute, memory and writeback over the shared instruction/data memory and the ALU, which also computes PC+4 and branch targets. It drives every datapath select and enable, including PCSrc for mux_pcsrc and the PC write enable. It supports memory wait states and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter
OP_W, 6, opcode field width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  OP_W  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access
pc_en  out  1  PC load enable, already combined with the branch condition
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  destination register: 0 = rt, 1 = rd
mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A operand: 0 = PC, 1 = rs
alu_src_b  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_op  out  2  00 = add, 01 = sub, 10 = decode funct
pc_src  out  2  to mux_pcsrc: 00 = ALU result, 01 = ALUOut (branch), 10 = jump address
illegal  out  1  one-cycle pulse on an unsupported opcode
state  out  4  current state, for debug
instr_count  out  CNT_W  number of retired instructions

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Encodings 12-15 go to FETCH on the next edge; all outputs are 0 in those states.
- Reset (synchronous; takes priority even mid-instruction or mid-stall):
  - state = FETCH, instr_count = 0, illegal = 0.
  - All control outputs are Moore functions of state, so they take their FETCH values on the next cycle.
  - No write strobe may be asserted in the cycle reset is sampled.
- Outputs that are not listed for a state are 0.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en are asserted only when mem_ready=1, then go to DECODE.
  - Otherwise stay in FETCH, holding all other outputs.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> RTEXEC
  - 0x23 (lw) or 0x2B (sw) -> MEMADR
  - 0x04 (beq) -> BRANCH
  - 0x08 (addi) -> ADDIEXEC
  - 0x02 (j) -> JUMP
  - any other opcode -> FETCH, with illegal=1 registered for exactly one cycle (the first FETCH cycle); instr_count does not increment.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Go to MEMWB when mem_ready=1, else hold.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR: iord=1, mem_write=1. Go to FETCH when mem_ready=1, else hold with mem_write kept high.
- RTEXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero -> FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- JUMP: pc_src=10, pc_en=1 -> FETCH.
- instr_count:
  - Increments by 1 on the edge leaving MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and MEMWR (MEMWR only when mem_ready=1).
  - Wraps modulo 2^CNT_W.
- Cycle cost with mem_ready tied to 1:
  - lw = 5 cycles
  - R-type, addi, sw = 4 cycles
  - beq, j = 3 cycles
  - Each wait cycle (mem_ready=0) adds 1 cycle.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

Test Plan:
- Reset held high for 3 cycles, then released with mem_ready=1, opcode=0x00 -> state sequence 0,1,6,7,0; reg_write=1 only in ALUWB; instr_count=1 after 4 cycles.
- lw (0x23) with mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; mem_read stays high throughout MEMRD; instr_count increments exactly once.
- beq (0x04) with zero=1, then zero=0 -> pc_en=1 with pc_src=01 in BRANCH for the first, pc_en=0 for the second; both take 3 cycles and both increment instr_count.
- Opcode 0x3F in DECODE -> next state FETCH, illegal=1 for exactly one cycle, instr_count unchanged.
- Reset asserted during MEMWR while mem_ready=0 -> mem_write=0 on the following cycle, state=0, instr_count=0.
- Preload instr_count to 0xFFFFFFFF via 2^32-1 j instructions (or force in the bench), then execute j -> instr_count=0 and pc_en=1 with pc_src=10.
